// File: rtl/ppwm_ch_sched.sv
// Round-robin scheduler sharing one execution unit among NUM_CH PWM channels.
// Grants a pending channel, pulses ex_start_o, then stores ex_value_i or aborts on timeout.
module ppwm_ch_sched #(
  parameter int NUM_CH        = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int TIMEOUT       = 64,
  localparam int CH_W         = $clog2(NUM_CH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable_i,
  input  logic [NUM_CH-1:0]               req_i,
  output logic                            ex_start_o,
  output logic [CH_W-1:0]                 ex_ch_o,
  input  logic                            ex_done_i,
  input  logic [COUNTER_WIDTH-1:0]        ex_value_i,
  output logic [NUM_CH*COUNTER_WIDTH-1:0] cmp_value_o,
  output logic [NUM_CH-1:0]               cmp_update_o,
  output logic                            busy_o,
  output logic [NUM_CH-1:0]               overrun_o,
  output logic                            timeout_o,
  input  logic                            clr_err_i
);

  localparam int TW = $clog2(TIMEOUT);
  // Last WAIT count before abort: the counter would reach TIMEOUT-1 on the next cycle.
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t                     state_q, state_d;
  logic [NUM_CH-1:0]          pending_q, pending_d, pending_clr;
  logic [NUM_CH-1:0]          overrun_q, overrun_d;
  logic [NUM_CH-1:0]          upd_q, upd_d;
  logic [CH_W-1:0]            rr_q, rr_d;
  logic [CH_W-1:0]            ex_ch_q, ex_ch_d;
  logic [TW-1:0]              cnt_q, cnt_d;
  logic                       timeout_q, timeout_d;
  logic [COUNTER_WIDTH-1:0]   cmp_q [NUM_CH];
  logic                       cmp_we, timeout_set;
  logic                       grant_vld;
  logic [CH_W-1:0]            grant_ch;
  logic [CH_W-1:0]            idx_w;
  int                         idx;

  // First pending channel strictly after the rr pointer, wrapping modulo NUM_CH.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx   = (int'(rr_q) + i) % NUM_CH;
      idx_w = CH_W'(idx);
      if (!grant_vld && pending_q[idx_w]) begin
        grant_vld = 1'b1;
        grant_ch  = idx_w;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ex_ch_d     = ex_ch_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    pending_clr = '0;
    cmp_we      = 1'b0;
    timeout_set = 1'b0;
    ex_start_o  = 1'b0;
    upd_d       = '0;
    case (state_q)
      S_IDLE: begin
        if (enable_i && grant_vld) begin
          state_d               = S_START;
          ex_ch_d               = grant_ch;
          rr_d                  = grant_ch;
          pending_clr[grant_ch] = 1'b1;
        end
      end
      S_START: begin
        ex_start_o = 1'b1;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (ex_done_i) begin
          cmp_we         = 1'b1;
          upd_d[ex_ch_q] = 1'b1;
          state_d        = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request in the same cycle as its grant re-arms pending without flagging overrun.
    pending_d = (pending_q & ~pending_clr) | req_i;
    overrun_d = (clr_err_i ? '0 : overrun_q) | (req_i & pending_q & ~pending_clr);
    timeout_d = (clr_err_i ? 1'b0 : timeout_q) | timeout_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      upd_q     <= '0;
      rr_q      <= CH_W'(NUM_CH - 1);
      ex_ch_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) cmp_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      upd_q     <= upd_d;
      rr_q      <= rr_d;
      ex_ch_q   <= ex_ch_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      if (cmp_we) cmp_q[ex_ch_q] <= ex_value_i;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_cmp
    assign cmp_value_o[k*COUNTER_WIDTH +: COUNTER_WIDTH] = cmp_q[k];
  end

  assign ex_ch_o      = ex_ch_q;
  assign cmp_update_o = upd_q;
  assign busy_o       = (state_q != S_IDLE);
  assign overrun_o    = overrun_q;
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_ppwm_ch_sched.sv
// Bench for ppwm_ch_sched: directed scenarios plus randomized traffic against a
// transaction-level model of pending requests, round-robin order and stored values.
module tb_ppwm_ch_sched;
  localparam int NCH  = 4;
  localparam int CW   = 8;
  localparam int TO   = 64;
  localparam int MAXC = 8192;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            enable_i = 1'b0;
  logic [NCH-1:0]  req_i = '0;
  logic            ex_done_i = 1'b0;
  logic [CW-1:0]   ex_value_i = '0;
  logic            clr_err_i = 1'b0;
  logic            ex_start_o;
  logic [1:0]      ex_ch_o;
  logic [NCH*CW-1:0] cmp_value_o;
  logic [NCH-1:0]  cmp_update_o;
  logic            busy_o;
  logic [NCH-1:0]  overrun_o;
  logic            timeout_o;

  ppwm_ch_sched #(.NUM_CH(NCH), .COUNTER_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .req_i(req_i),
    .ex_start_o(ex_start_o), .ex_ch_o(ex_ch_o), .ex_done_i(ex_done_i),
    .ex_value_i(ex_value_i), .cmp_value_o(cmp_value_o), .cmp_update_o(cmp_update_o),
    .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o), .clr_err_i(clr_err_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle log of driven inputs; index = cycle number during which the value was applied.
  int             cyc = 0;
  logic [NCH-1:0] req_hist [MAXC];
  logic           en_hist  [MAXC];

  always @(posedge clk) begin
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    req_hist[cyc] = req_i;
    en_hist[cyc]  = enable_i;
    cyc = cyc + 1;
  end

  // Reference model: set of pending channels, last granted channel, sticky overruns.
  bit          mp   [NCH];
  bit          movr [NCH];
  int          mrr = NCH - 1;
  int          applied = -1;
  logic [CW-1:0] exp_cmp [NCH];

  typedef struct { int ch; logic [CW-1:0] val; int cyc; } upd_t;
  upd_t updq [$];
  int   glog [$];
  int   nstart = 0;
  int   upd_cnt [NCH];

  function automatic void apply_to(input int upto);
    for (int c = applied + 1; c <= upto; c++) begin
      for (int k = 0; k < NCH; k++) begin
        if (req_hist[c][k]) begin
          if (mp[k]) movr[k] = 1'b1;
          mp[k] = 1'b1;
        end
      end
    end
    if (upto > applied) applied = upto;
  endfunction

  // Responder behaviour: 0 = answer and expect an update, 2 = answer but expect nothing.
  int          resp_mode = 0;
  int          lat_min = 3, lat_max = 3;
  int          val_mode = 0;
  logic [CW-1:0] val_fixed = 8'hA5;

  // Shared execution unit model.
  always begin
    int r_ch, r_c, r_lat, r_mode;
    logic [CW-1:0] r_val;
    @(negedge clk);
    if (ex_start_o) begin
      r_ch   = int'(ex_ch_o);
      r_c    = cyc;
      r_mode = resp_mode;
      r_lat  = int'($urandom_range(lat_max, lat_min));
      repeat (r_lat) @(posedge clk);
      #1;
      if (val_mode == 1)      r_val = val_fixed;
      else if (val_mode == 2) r_val = 8'(16 + r_ch);
      else                    r_val = 8'($urandom);
      ex_done_i  = 1'b1;
      ex_value_i = r_val;
      if (r_mode == 0) updq.push_back('{ch: r_ch, val: r_val, cyc: r_c + r_lat + 1});
      @(posedge clk);
      #1;
      ex_done_i = 1'b0;
    end
  end

  // Monitor: grants against the model, updates against the scoreboard queue.
  always @(negedge clk) begin
    int found;
    upd_t e;
    logic [NCH*CW-1:0] ev;
    if (ex_start_o) begin
      nstart++;
      // Grant decided in the previous cycle sees requests up to two cycles back.
      apply_to(cyc - 2);
      found = -1;
      for (int i = 1; i <= NCH; i++)
        if (found < 0 && mp[(mrr + i) % NCH]) found = (mrr + i) % NCH;
      if (found < 0) begin
        check("grant_without_pending", 64'(ex_ch_o), 64'hFF);
      end else begin
        check("grant_ch", 64'(ex_ch_o), 64'(found));
        mp[found] = 1'b0;
        mrr = found;
      end
      check("grant_enable", 64'(en_hist[cyc-1]), 64'd1);
      glog.push_back(int'(ex_ch_o));
    end
    while (updq.size() > 0 && updq[0].cyc < cyc) begin
      e = updq.pop_front();
      check("missed_update_cycle", 64'(cyc), 64'(e.cyc));
    end
    if (cmp_update_o != '0) begin
      if (updq.size() == 0) begin
        check("unexpected_update", 64'(cmp_update_o), 64'd0);
      end else begin
        e = updq.pop_front();
        check("upd_strobe", 64'(cmp_update_o), 64'(1 << e.ch));
        check("upd_cycle", 64'(cyc), 64'(e.cyc));
        check("upd_busy", 64'(busy_o), 64'd0);
        exp_cmp[e.ch] = e.val;
        upd_cnt[e.ch]++;
      end
    end
    for (int k = 0; k < NCH; k++) ev[k*CW +: CW] = exp_cmp[k];
    check("cmp_value", 64'(cmp_value_o), 64'(ev));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    int r;
    tick();
    rst = 1'b1;
    r = cyc;
    @(posedge clk);
    for (int k = 0; k < NCH; k++) begin
      mp[k] = 1'b0; movr[k] = 1'b0; exp_cmp[k] = '0; upd_cnt[k] = 0;
    end
    mrr = NCH - 1;
    applied = r;
    updq.delete();
    glog.delete();
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [NCH-1:0] v, output int t);
    req_i = v;
    t = cyc;
    tick();
    req_i = '0;
  endtask

  task automatic wait_start(output int s, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ex_start_o && n < budget);
    check("wait_start_seen", 64'(ex_start_o), 64'd1);
    s = cyc;
  endtask

  task automatic wait_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic drain(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy_o) quiet++; else quiet = 0;
    end
    check("drain_idle", 64'(quiet >= 3), 64'd1);
  endtask

  task automatic check_overrun_model(input string name);
    apply_to(cyc - 2);
    for (int k = 0; k < NCH; k++) check(name, 64'(overrun_o[k]), 64'(movr[k]));
  endtask

  task automatic pulse_clr();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    for (int k = 0; k < NCH; k++) movr[k] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t, s, c0, c1, c3;
    logic [NCH-1:0] rv;

    do_reset();
    @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_start", 64'(ex_start_o), 64'd0);
    check("rst_ch", 64'(ex_ch_o), 64'd0);
    check("rst_cmp", 64'(cmp_value_o), 64'd0);
    check("rst_upd", 64'(cmp_update_o), 64'd0);
    check("rst_ovr", 64'(overrun_o), 64'd0);
    check("rst_to", 64'(timeout_o), 64'd0);

    // Single request, fixed result.
    enable_i = 1'b1;
    resp_mode = 0; lat_min = 3; lat_max = 3; val_mode = 1; val_fixed = 8'hA5;
    tick();
    pulse_req(4'b0001, t);
    wait_start(s, 20);
    check("t1_start_lat", 64'(s), 64'(t + 2));
    check("t1_ch", 64'(ex_ch_o), 64'd0);
    drain(50);
    check("t1_cmp0", 64'(cmp_value_o[7:0]), 64'hA5);
    check("t1_upd_once", 64'(upd_cnt[0]), 64'd1);

    // All four at once: served 0..3 in order.
    do_reset();
    val_mode = 2;
    pulse_req(4'b1111, t);
    drain(200);
    check("t2_ngrants", 64'(glog.size()), 64'd4);
    for (int i = 0; i < NCH && i < glog.size(); i++) check("t2_order", 64'(glog[i]), 64'(i));
    for (int k = 0; k < NCH; k++) check("t2_upd_once", 64'(upd_cnt[k]), 64'd1);
    check("t2_cmp", 64'(cmp_value_o), 64'h13121110);
    check("t2_no_ovr", 64'(overrun_o), 64'd0);

    // Ch2 requests every 5 cycles against a slow unit.
    do_reset();
    lat_min = 20; lat_max = 20; val_mode = 0;
    for (int i = 0; i < 100; i++) begin
      rv = '0;
      if (i % 5 == 0) rv[2] = 1'b1;
      if (i == 0) rv = rv | 4'b1011;
      req_i = rv;
      tick();
    end
    req_i = '0;
    drain(400);
    check_overrun_model("t3_ovr_model");
    check("t3_ovr2", 64'(overrun_o[2]), 64'd1);
    c0 = 0; c1 = 0; c3 = 0;
    foreach (glog[i]) begin
      if (glog[i] == 0) c0++;
      if (glog[i] == 1) c1++;
      if (glog[i] == 3) c3++;
    end
    check("t3_served_013", 64'((c0 > 0) && (c1 > 0) && (c3 > 0)), 64'd1);
    pulse_clr();
    check("t3_ovr_clr", 64'(overrun_o), 64'd0);

    // Unit never answers in time.
    do_reset();
    resp_mode = 2; lat_min = 70; lat_max = 70;
    pulse_req(4'b0001, t);
    wait_start(s, 20);
    wait_cyc(s + TO - 1);
    check("t4_busy_before", 64'(busy_o), 64'd1);
    check("t4_to_before", 64'(timeout_o), 64'd0);
    wait_cyc(s + TO);
    check("t4_busy_after", 64'(busy_o), 64'd0);
    check("t4_to_after", 64'(timeout_o), 64'd1);
    wait_cyc(s + 75);
    check("t4_cmp_unchanged", 64'(cmp_value_o), 64'd0);
    check("t4_to_sticky", 64'(timeout_o), 64'd1);
    pulse_clr();
    check("t4_to_clr", 64'(timeout_o), 64'd0);

    // Requests held back while disabled.
    do_reset();
    enable_i = 1'b0;
    resp_mode = 0; lat_min = 2; lat_max = 2; val_mode = 1; val_fixed = 8'h5A;
    nstart = 0;
    pulse_req(4'b0110, t);
    repeat (10) tick();
    check("t5_no_start", 64'(nstart), 64'd0);
    enable_i = 1'b1;
    drain(100);
    check("t5_ngrants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      check("t5_first", 64'(glog[0]), 64'd1);
      check("t5_second", 64'(glog[1]), 64'd2);
    end

    // Reset while ch3 is being evaluated.
    check("t6_pre_cmp", 64'(cmp_value_o), 64'h005A5A00);
    resp_mode = 2; lat_min = 10; lat_max = 10;
    pulse_req(4'b1000, t);
    wait_start(s, 20);
    check("t6_ch3", 64'(ex_ch_o), 64'd3);
    wait_cyc(s + 2);
    do_reset();
    @(negedge clk);
    check("t6_busy", 64'(busy_o), 64'd0);
    check("t6_start", 64'(ex_start_o), 64'd0);
    check("t6_ch", 64'(ex_ch_o), 64'd0);
    check("t6_cmp", 64'(cmp_value_o), 64'd0);
    check("t6_upd", 64'(cmp_update_o), 64'd0);
    check("t6_flags", 64'({overrun_o, timeout_o}), 64'd0);
    wait_cyc(s + 15);
    check("t6_late_done_ignored", 64'(cmp_value_o), 64'd0);

    // Randomized traffic with enable toggling.
    do_reset();
    resp_mode = 0; lat_min = 1; lat_max = 8; val_mode = 0;
    nstart = 0;
    for (int i = 0; i < 1500; i++) begin
      enable_i = ($urandom_range(9, 0) != 0);
      for (int k = 0; k < NCH; k++) rv[k] = ($urandom_range(7, 0) == 0);
      req_i = rv;
      tick();
    end
    req_i = '0;
    enable_i = 1'b1;
    drain(400);
    check_overrun_model("rnd_ovr_model");
    check("rnd_activity", 64'(nstart > 50), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got time %0t expected earlier finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ppwm_ch_sched.md
Name: ppwm_ch_sched

Overview:
Scheduler that time-shares one instruction-execution unit and its instruction memory among NUM_CH PWM channels. Each channel's PWM generator raises a period-start request. The scheduler arbitrates requests round-robin, starts the shared execution unit with the selected channel id (the upper memory address bits), captures the result, and holds a per-channel compare value with an update strobe. It sits between the per-channel PWM generators and the single shared ex/mem pair.

Parameters:
NUM_CH, 4, number of PWM channels (2..8)
COUNTER_WIDTH, 8, width of compare value / ex result
CH_W, $clog2(NUM_CH), channel-id width (derived, not overridable)
TIMEOUT, 64, max cycles to wait for ex_done_i before abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
enable_i  in  1  permits new grants; in-flight evaluation always completes
req_i  in  NUM_CH  per-channel period-start pulse
ex_start_o  out  1  one-cycle start pulse to shared ex unit
ex_ch_o  out  CH_W  channel under evaluation, stable from START until return to IDLE
ex_done_i  in  1  ex result valid (one-cycle pulse)
ex_value_i  in  COUNTER_WIDTH  ex result, valid with ex_done_i
cmp_value_o  out  NUM_CH*COUNTER_WIDTH  held compare values; channel k at [k*COUNTER_WIDTH +: COUNTER_WIDTH]
cmp_update_o  out  NUM_CH  one-cycle strobe per channel, high in the cycle its cmp_value changes
busy_o  out  1  high when FSM not IDLE
overrun_o  out  NUM_CH  sticky: request arrived while same channel already pending
timeout_o  out  1  sticky: an evaluation aborted by timeout
clr_err_i  in  1  clears overrun_o and timeout_o

Behaviour:
- Reset: FSM=IDLE, pending=0, rr pointer=NUM_CH-1 (so ch0 wins first), all cmp values=0, ex_ch_o=0, all strobes/flags=0. Reset mid-evaluation abandons it; a later ex_done_i is ignored in IDLE.
- Pending: pending[k] is set on req_i[k]=1 and cleared when channel k is granted.
  - Set and clear in the same cycle: set wins, no overrun.
  - req_i[k] while pending[k] already set and not being cleared: overrun_o[k]<=1 and the request coalesces.
  - clr_err_i clears the flags; a same-cycle new error sets them (set wins).
- FSM IDLE -> START: when enable_i=1 and pending!=0.
  - Grant the first pending channel searching upward from rr+1, with modular wrap.
  - Register ex_ch_o, clear pending, set rr to the granted channel.
- START: ex_start_o=1 for exactly one cycle -> WAIT; clear the wait counter. ex_done_i in START is ignored.
- WAIT: the counter increments each cycle.
  - On ex_done_i=1: next cycle cmp_value[ex_ch_o]<=ex_value_i, cmp_update_o[ex_ch_o]=1 for one cycle, FSM -> IDLE.
  - If the counter reaches TIMEOUT-1 without done: timeout_o<=1, cmp value unchanged, no strobe, -> IDLE.
- Latency: req_i[k] at cycle t, with the FSM idle and nothing else pending -> pending at t+1 -> ex_start_o at t+2. ex_done_i at cycle d -> cmp_update_o and the new value at d+1. IDLE is re-entered at d+1, so the next grant is at d+1 and ex_start_o at d+2.
- Round-robin guarantees each pending channel a grant within NUM_CH evaluations.
- enable_i=0: no IDLE->START transition. Requests still set pending and overrun.
- Values are stored unmodified (no arithmetic). Width mismatches are illegal by construction.

Test Plan:
- Reset then req_i=4'b0001 at t -> ex_start_o at t+2, ex_ch_o=0. ex_done_i with ex_value_i=8'hA5 at d -> cmp_value ch0=8'hA5 and cmp_update_o=4'b0001 at d+1 only, busy_o low at d+1.
- req_i=4'b1111 in one cycle, ex returns 8'h10+ch after 3 cycles -> grants in order 0,1,2,3, each cmp value updated once, no overrun.
- Ch2 requests every 5 cycles while the ex latency is 20 cycles -> overrun_o[2]=1 and ch0/1/3 are still served round-robin. clr_err_i -> overrun_o=0 next cycle.
- ex_done_i never asserted, TIMEOUT=64 -> FSM in IDLE 64 cycles after START, timeout_o=1, cmp value and strobes unchanged. A late ex_done_i is ignored.
- enable_i=0 with pending=4'b0110 -> no ex_start_o. Raise enable_i -> ch1 granted first, then ch2.
- Assert rst during WAIT for ch3 -> all outputs 0 next cycle. The subsequent ex_done_i causes no update.
